// File: rtl/rk_pkg.sv
// Shared types and checksum arithmetic for the RK tape image loader.
package rk_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC, ST_HDR, ST_DATA, ST_TAIL, ST_CS_HI, ST_CS_LO, ST_DONE, ST_ERR
  } rk_state_t;

  localparam logic [7:0] RK_SYNC     = 8'hE6;
  localparam int         RK_TAIL_LEN = 3;
  localparam int         RK_TAIL_WIN = 4;
  // Tail byte index beyond which a missing E6 marker is fatal (00 00 + 4-byte window).
  localparam logic [2:0] RK_TAIL_LAST = 3'(RK_TAIL_LEN + RK_TAIL_WIN - 2);

  function automatic logic [15:0] rk_cs_step(input logic [15:0] cs, input logic [7:0] b,
                                             input logic last);
    logic [8:0] lo;
    logic [7:0] hi;
    lo = {1'b0, cs[7:0]} + {1'b0, b};
    hi = last ? cs[15:8] : cs[15:8] + b + {7'b0, lo[8]};
    return {hi, lo[7:0]};
  endfunction

endpackage

// File: rtl/rk_checksum.sv
// RK 16-bit tape checksum accumulator; clear has priority over en.
module rk_checksum
  import rk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        last,
  input  logic [7:0]  din,
  output logic [15:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) sum <= 16'h0000;
    else if (en)        sum <= rk_cs_step(sum, din, last);
  end

endmodule

// File: rtl/rk_tape_loader.sv
// RK tape image parser: header decode, RAM write strobes (1-cycle latency), tail/checksum check.
// One byte per clock; no backpressure on the download side.
module rk_tape_loader
  import rk_pkg::*;
#(
  parameter bit SKIP_SYNC  = 1'b1,
  parameter bit CHECK_TAIL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl,
  input  logic        in_wr,
  input  logic [7:0]  in_data,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic [15:0] start_addr,
  output logic        done,
  output logic        err,
  output logic        busy
);

  rk_state_t   state, state_nxt;
  logic        dl_q;
  logic [1:0]  hdr_cnt;
  logic [15:0] hdr_start;
  logic [7:0]  end_hi;
  logic [15:0] end_addr;
  logic [15:0] ptr;
  logic [2:0]  tail_cnt;
  logic        hi_ok;
  logic [15:0] cs;

  wire         dl_rise  = dl & ~dl_q;
  wire         dl_fall  = ~dl & dl_q;
  // A byte arriving with the dl rising edge belongs to no image yet.
  wire         byte_vld = in_wr & dl & ~dl_rise;
  wire  [15:0] hdr_end  = {end_hi, in_data};
  wire         at_end   = (ptr == end_addr);

  rk_checksum u_cs (
    .clk   (clk),
    .reset (reset),
    .clear (dl_rise),
    .en    (byte_vld && state == ST_DATA),
    .last  (at_end),
    .din   (in_data),
    .sum   (cs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      dl_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      dl_q  <= dl;
    end
  end

  always_comb begin
    state_nxt = state;
    if (dl_rise) begin
      state_nxt = SKIP_SYNC ? ST_SYNC : ST_HDR;
    end else if (dl_fall && busy) begin
      state_nxt = ST_ERR;
    end else if (byte_vld) begin
      case (state)
        ST_SYNC:  state_nxt = ST_HDR;
        ST_HDR:   if (hdr_cnt == 2'd3) state_nxt = (hdr_end < hdr_start) ? ST_ERR : ST_DATA;
        ST_DATA:  if (at_end) state_nxt = CHECK_TAIL ? ST_TAIL : ST_DONE;
        ST_TAIL: begin
          if (tail_cnt < 3'd2) begin
            if (in_data != 8'h00) state_nxt = ST_ERR;
          end else if (in_data == RK_SYNC) begin
            state_nxt = ST_CS_HI;
          end else if (in_data != 8'h00 || tail_cnt == RK_TAIL_LAST) begin
            state_nxt = ST_ERR;
          end
        end
        ST_CS_HI: state_nxt = ST_CS_LO;
        ST_CS_LO: state_nxt = (hi_ok && in_data == cs[7:0]) ? ST_DONE : ST_ERR;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = !(state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    done = (state == ST_DONE);
    err  = (state == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we     <= 1'b0;
      ram_addr   <= 16'h0000;
      ram_din    <= 8'h00;
      start_addr <= 16'h0000;
      hdr_cnt    <= 2'd0;
      hdr_start  <= 16'h0000;
      end_hi     <= 8'h00;
      end_addr   <= 16'h0000;
      ptr        <= 16'h0000;
      tail_cnt   <= 3'd0;
      hi_ok      <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (dl_rise) begin
        hdr_cnt  <= 2'd0;
        tail_cnt <= 3'd0;
        hi_ok    <= 1'b0;
      end else if (byte_vld) begin
        case (state)
          ST_SYNC: if (in_data != RK_SYNC) begin
            hdr_start[15:8] <= in_data;
            hdr_cnt         <= 2'd1;
          end
          ST_HDR: begin
            hdr_cnt <= hdr_cnt + 2'd1;
            case (hdr_cnt)
              2'd0: hdr_start[15:8] <= in_data;
              2'd1: hdr_start[7:0]  <= in_data;
              2'd2: end_hi          <= in_data;
              default: if (!(hdr_end < hdr_start)) begin
                ptr        <= hdr_start;
                end_addr   <= hdr_end;
                start_addr <= hdr_start;
              end
            endcase
          end
          ST_DATA: begin
            ram_we   <= 1'b1;
            ram_addr <= ptr;
            ram_din  <= in_data;
            ptr      <= ptr + 16'd1;
          end
          ST_TAIL:  tail_cnt <= tail_cnt + 3'd1;
          ST_CS_HI: hi_ok    <= (in_data == cs[15:8]);
          default: ;
        endcase
      end
    end
  end

endmodule
